// File: rtl/mc_pkg.sv
// Shared state, instruction-class and field definitions for the multicycle controller.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_ALU_R,
    CLS_ALU_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JMP,
    CLS_HALT,
    CLS_RSVD
  } ins_class_e;

  localparam int OP_HI   = 18;
  localparam int OP_LO   = 14;
  localparam int FUNC_HI = 16;
  localparam int FUNC_LO = 14;

  localparam logic [1:0] GRP_ALU_R  = 2'b00;
  localparam logic [1:0] GRP_ALU_I  = 2'b01;
  localparam logic [2:0] GRP_MEM    = 3'b100;
  localparam logic [2:0] GRP_BRANCH = 3'b101;
  localparam logic [2:0] GRP_JMP    = 3'b110;
  localparam logic [2:0] GRP_HALT   = 3'b111;

  localparam logic [1:0] MEM_LOAD  = 2'b00;
  localparam logic [1:0] MEM_STORE = 2'b01;

  localparam logic [1:0] BR_Z  = 2'b00;
  localparam logic [1:0] BR_NZ = 2'b01;
  localparam logic [1:0] BR_C  = 2'b10;
  localparam logic [1:0] BR_NC = 2'b11;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] FUNC_RSVD = 3'b111;

endpackage

// File: rtl/mc_decoder.sv
// Combinational instruction classifier: maps opcode bits ir[18:14] to a class and
// resolves the branch condition against the committed Z/C flags.
module mc_decoder
  import mc_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic        z_i,
  input  logic        c_i,
  output ins_class_e  cls_o,
  output logic        taken_o
);

  always_comb begin
    cls_o   = CLS_RSVD;
    taken_o = 1'b0;
    if (op_i[4:3] == GRP_ALU_R || op_i[4:3] == GRP_ALU_I) begin
      if (op_i[2:0] != FUNC_RSVD) begin
        if (op_i[4:3] == GRP_ALU_R) cls_o = CLS_ALU_R;
        else                        cls_o = CLS_ALU_I;
      end
    end else begin
      case (op_i[4:2])
        GRP_MEM: begin
          if (op_i[1:0] == MEM_LOAD)       cls_o = CLS_LOAD;
          else if (op_i[1:0] == MEM_STORE) cls_o = CLS_STORE;
        end
        GRP_BRANCH: begin
          cls_o = CLS_BRANCH;
          case (op_i[1:0])
            BR_Z:    taken_o = z_i;
            BR_NZ:   taken_o = !z_i;
            BR_C:    taken_o = c_i;
            default: taken_o = !c_i;
          endcase
        end
        GRP_JMP:  cls_o = CLS_JMP;
        GRP_HALT: cls_o = CLS_HALT;
        default:  cls_o = CLS_RSVD;
      endcase
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: PC, IR, Z/C flags and the FETCH/DECODE/EXEC/MEM/WB sequencer.
// Define MC_CTRL_TRAP_EN to trap reserved encodings to TRAP_VECTOR instead of running them as NOPs.
module mc_controller
  import mc_pkg::*;
#(
  parameter int              PC_W        = 12,
  parameter int              INS_W       = 19,
  parameter logic [PC_W-1:0] TRAP_VECTOR = 12'hFF0
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [PC_W-1:0]  imem_addr,
  input  logic [INS_W-1:0] imem_ins,
  output logic [INS_W-1:0] ir,
  output logic [2:0]       alu_op,
  output logic             alu_src_imm,
  output logic             carry_in,
  input  logic             alu_zero,
  input  logic             alu_carry,
  output logic             reg_write,
  output logic             wb_sel_mem,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  output logic             halted,
  output logic             illegal
);

`ifdef MC_CTRL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [INS_W-1:0] ir_q, ir_d;
  logic             zFlag_q, zFlag_d, cFlag_q, cFlag_d;
  logic             zPend_q, zPend_d, cPend_q, cPend_d;
  logic             illegal_q, illegal_d;
  ins_class_e       insClass;
  logic             brTaken;
  logic             isAlu;

  mc_decoder u_decoder (
    .op_i    (ir_q[OP_HI:OP_LO]),
    .z_i     (zFlag_q),
    .c_i     (cFlag_q),
    .cls_o   (insClass),
    .taken_o (brTaken)
  );

  assign isAlu     = (insClass == CLS_ALU_R) || (insClass == CLS_ALU_I);
  assign imem_addr = pc_q;
  assign ir        = ir_q;
  assign carry_in  = cFlag_q;
  assign illegal   = illegal_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    zFlag_d     = zFlag_q;
    cFlag_d     = cFlag_q;
    zPend_d     = zPend_q;
    cPend_d     = cPend_q;
    illegal_d   = illegal_q;
    alu_op      = ALU_ADD;
    alu_src_imm = 1'b0;
    reg_write   = 1'b0;
    wb_sel_mem  = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    halted      = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_d    = imem_ins;
        pc_d    = pc_q + PC_W'(1);
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d = ST_FETCH;
        case (insClass)
          CLS_BRANCH: if (brTaken) pc_d = ir_q[PC_W-1:0];
          CLS_JMP:    pc_d = ir_q[PC_W-1:0];
          CLS_HALT:   state_d = ST_HALT;
          CLS_ALU_R, CLS_ALU_I, CLS_LOAD, CLS_STORE: state_d = ST_EXEC;
          default: begin
            if (TRAP_EN) begin
              pc_d      = TRAP_VECTOR;
              illegal_d = 1'b1;
            end
          end
        endcase
      end
      // Memory ops use the ALU as an ADD address generator with the immediate offset.
      ST_EXEC: begin
        alu_src_imm = (insClass != CLS_ALU_R);
        if (isAlu) begin
          alu_op  = ir_q[FUNC_HI:FUNC_LO];
          zPend_d = alu_zero;
          cPend_d = alu_carry;
          state_d = ST_WB;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (insClass == CLS_STORE);
        if (dmem_ready) begin
          if (insClass == CLS_STORE) state_d = ST_FETCH;
          else                       state_d = ST_WB;
        end
      end
      ST_WB: begin
        reg_write = 1'b1;
        state_d   = ST_FETCH;
        if (insClass == CLS_LOAD) begin
          wb_sel_mem = 1'b1;
        end else begin
          zFlag_d = zPend_q;
          cFlag_d = cPend_q;
        end
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      zFlag_q   <= 1'b0;
      cFlag_q   <= 1'b0;
      zPend_q   <= 1'b0;
      cPend_q   <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      zFlag_q   <= zFlag_d;
      cFlag_q   <= cFlag_d;
      zPend_q   <= zPend_d;
      cPend_q   <= cPend_d;
      illegal_q <= illegal_d;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Randomized bench for mc_controller: an instruction-level model predicts PC, flags,
// per-cycle strobes and latency for directed and random instruction streams.
module tb_mc_controller;

`ifdef MC_CTRL_TRAP_EN
  localparam bit trapEn = 1'b1;
`else
  localparam bit trapEn = 1'b0;
`endif
  localparam logic [11:0] trapVector = 12'hFF0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [11:0] imem_addr;
  logic [18:0] imem_ins;
  logic [18:0] ir;
  logic [2:0]  alu_op;
  logic        alu_src_imm, carry_in, alu_zero, alu_carry;
  logic        reg_write, wb_sel_mem, dmem_req, dmem_we, dmem_ready;
  logic        halted, illegal;

  logic [18:0] imem [0:4095];
  int          total = 0;
  int          bad = 0;
  logic [11:0] mPc;
  bit          mZ, mC, mIll;

  assign imem_ins = imem[imem_addr];

  mc_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_addr   (imem_addr),
    .imem_ins    (imem_ins),
    .ir          (ir),
    .alu_op      (alu_op),
    .alu_src_imm (alu_src_imm),
    .carry_in    (carry_in),
    .alu_zero    (alu_zero),
    .alu_carry   (alu_carry),
    .reg_write   (reg_write),
    .wb_sel_mem  (wb_sel_mem),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_ready  (dmem_ready),
    .halted      (halted),
    .illegal     (illegal)
  );

  initial forever #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic noise();
    dmem_ready = 1'($urandom);
    alu_zero   = 1'($urandom);
    alu_carry  = 1'($urandom);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    noise();
    repeat (2) @(negedge clk);
    checkOutput("reset_pc", 32'(imem_addr), 32'h0);
    checkOutput("reset_ir", 32'(ir), 32'h0);
    checkOutput("reset_status", 32'({halted, illegal, carry_in, reg_write, dmem_req, dmem_we}), 32'h0);
    rst_n = 1'b1;
    mPc = '0; mZ = 1'b0; mC = 1'b0; mIll = 1'b0;
  endtask

  // Runs one instruction from its FETCH cycle; called at a negedge with the DUT in FETCH.
  task automatic applyStimulus(input logic [18:0] ins, input int nMem, input bit az, input bit ac);
    logic [1:0]  grp2, sub;
    logic [2:0]  grp3, func;
    logic [11:0] tgt, nextPc;
    bit          isAlu, isMem, isStore, isBr, isJmp, isHalt, taken;
    grp2 = ins[18:17]; grp3 = ins[18:16]; func = ins[16:14]; sub = ins[15:14]; tgt = ins[11:0];
    isAlu   = (grp2 <= 2'd1) && (func != 3'd7);
    isMem   = (grp3 == 3'd4) && (sub <= 2'd1);
    isStore = isMem && (sub == 2'd1);
    isBr    = (grp3 == 3'd5);
    isJmp   = (grp3 == 3'd6);
    isHalt  = (grp3 == 3'd7);
    case (sub)
      2'd0:    taken = mZ;
      2'd1:    taken = !mZ;
      2'd2:    taken = mC;
      default: taken = !mC;
    endcase
    nextPc = mPc + 12'd1;
    imem[mPc] = ins;

    checkOutput("fetch_addr", 32'(imem_addr), 32'(mPc));
    checkOutput("fetch_status", 32'({halted, illegal, carry_in}), 32'({1'b0, mIll, mC}));
    checkOutput("fetch_strobes", 32'({reg_write, dmem_req, dmem_we}), 32'h0);
    noise();
    @(negedge clk);
    checkOutput("decode_ir", 32'(ir), 32'(ins));
    checkOutput("decode_pc", 32'(imem_addr), 32'(nextPc));
    checkOutput("decode_strobes", 32'({reg_write, dmem_req, dmem_we, halted}), 32'h0);
    noise();
    @(negedge clk);

    if (isAlu) begin
      checkOutput("exec_alu_op", 32'(alu_op), 32'(func));
      checkOutput("exec_src_imm", 32'(alu_src_imm), 32'(grp2 == 2'd1));
      checkOutput("exec_carry_in", 32'(carry_in), 32'(mC));
      checkOutput("exec_strobes", 32'({reg_write, dmem_req, dmem_we}), 32'h0);
      dmem_ready = 1'($urandom); alu_zero = az; alu_carry = ac;
      @(negedge clk);
      checkOutput("wb_alu", 32'({reg_write, wb_sel_mem, dmem_req, dmem_we}), 32'b1000);
      noise();
      @(negedge clk);
      mZ = az; mC = ac; mPc = nextPc;
    end else if (isMem) begin
      checkOutput("exec_addr_op", 32'(alu_op), 32'h0);
      checkOutput("exec_strobes", 32'({reg_write, dmem_req, dmem_we}), 32'h0);
      noise();
      @(negedge clk);
      for (int i = 0; i < nMem; i++) begin
        checkOutput("mem_req", 32'({dmem_req, dmem_we, reg_write}), 32'({1'b1, isStore, 1'b0}));
        noise();
        dmem_ready = (i == nMem - 1);
        @(negedge clk);
      end
      if (!isStore) begin
        checkOutput("wb_load", 32'({reg_write, wb_sel_mem, dmem_req}), 32'b110);
        noise();
        @(negedge clk);
      end
      mPc = nextPc;
    end else if (isHalt) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput("halt_hold", 32'({halted, reg_write, dmem_req}), 32'b100);
        checkOutput("halt_pc", 32'(imem_addr), 32'(nextPc));
        noise();
        @(negedge clk);
      end
      mPc = nextPc;
    end else if ((isBr && taken) || isJmp) begin
      mPc = tgt;
    end else if (!isBr && trapEn) begin
      mPc = trapVector;
      mIll = 1'b1;
    end else begin
      mPc = nextPc;
    end
  endtask

  initial begin
    logic [18:0] r;
    for (int i = 0; i < 4096; i++) imem[i] = '0;
    dmem_ready = 1'b0; alu_zero = 1'b0; alu_carry = 1'b0;
    @(negedge clk);
    doReset();

    applyStimulus(19'b00_000_011_001_010_00000, 1, 1'b0, 1'b0);
    applyStimulus(19'b00_000_011_001_010_00000, 1, 1'b0, 1'b1);
    applyStimulus(19'b00_001_011_011_001_00000, 1, 1'b0, 1'b1);
    applyStimulus(19'b100_01_00000000000000, 4, 1'b0, 1'b0);
    applyStimulus({3'b101, 2'b10, 2'b00, 12'h010}, 1, 1'b0, 1'b0);
    applyStimulus({3'b110, 4'b0000, 12'hFFF}, 1, 1'b0, 1'b0);
    applyStimulus({3'b101, (mZ ? 2'b01 : 2'b00), 2'b00, 12'h123}, 1, 1'b0, 1'b0);
    applyStimulus({5'b10011, 14'h0ABC}, 1, 1'b0, 1'b0);
    applyStimulus({5'b10000, 14'h0005}, 1, 1'b0, 1'b0);
    applyStimulus({5'b10000, 14'h0007}, 2, 1'b0, 1'b0);
    applyStimulus(19'b01_010_100_000_00001111, 1, 1'b1, 1'b0);
    applyStimulus({3'b101, 2'b00, 2'b00, 12'h200}, 1, 1'b0, 1'b0);

    for (int n = 0; n < 400; n++) begin
      r = 19'($urandom);
      if (r[18:16] == 3'b111) r[18:16] = 3'b110;
      applyStimulus(r, int'($urandom_range(1, 4)), 1'($urandom), 1'($urandom));
    end

    applyStimulus({3'b111, 16'h0}, 1, 1'b0, 1'b0);
    doReset();
    checkOutput("halt_cleared", 32'(halted), 32'h0);

    imem[0] = 19'b100_01_00000000000011;
    dmem_ready = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("mid_mem_req", 32'({dmem_req, dmem_we}), 32'b11);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_drops_req", 32'({dmem_req, dmem_we}), 32'h0);
    checkOutput("reset_mid_pc", 32'(imem_addr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    mPc = '0; mZ = 1'b0; mC = 1'b0; mIll = 1'b0;
    applyStimulus(19'b00_000_001_001_001_00000, 1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
